// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

  localparam int unsigned DATA_WIDTH_DEFAULT = 8;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic PAR_EVEN       = 1'b0;
  localparam logic PAR_ODD        = 1'b1;

  // One-hot so only two flops toggle per state change.
  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte request / serial line bundle between the system side and the UART transmitter.
interface uart_tx_ctrl_if import uart_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, Busy
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// Right-shifting data register with a bit counter; o_done flags the last data bit.
module uart_tx_serializer import uart_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_load,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_bit,
  output logic                  o_next_bit,
  output logic                  o_done
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] r_shift;
  logic [CntW-1:0]       r_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

  assign o_bit      = r_shift[0];
  // The line output is registered, so the FSM loads the bit that becomes current after the shift.
  assign o_next_bit = r_shift[1];
  assign o_done     = (r_cnt == LastCnt);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start, LSB-first data, optional parity, stop; one bit per CLK.
// Define UART_TX_TWO_STOP_EN for two stop bits (back-to-back window is the second one).
module uart_tx_ctrl import uart_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_ctrl_if.slave  bus
);

  uart_tx_state_e r_state;
  logic           r_tx_out;
  logic           r_busy;
  logic           r_par_en;
  logic           r_par_bit;
  logic           w_stop_last;
  logic           w_capture;
  logic           w_shift;
  logic           w_bit;
  logic           w_next_bit;
  logic           w_done;

`ifdef UART_TX_TWO_STOP_EN
  logic r_stop_second;
  assign w_stop_last = r_stop_second;
`else
  assign w_stop_last = 1'b1;
`endif

  assign w_capture = bus.Data_Valid &&
                     ((r_state == IDLE) || ((r_state == STOP) && w_stop_last));
  assign w_shift   = (r_state == DATA) && !w_done;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .CLK        (CLK),
    .RST        (RST),
    .i_load     (w_capture),
    .i_shift    (w_shift),
    .i_data     (bus.P_DATA),
    .o_bit      (w_bit),
    .o_next_bit (w_next_bit),
    .o_done     (w_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_tx_out  <= UART_IDLE_LVL;
      r_busy    <= 1'b0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
      r_stop_second <= 1'b0;
`endif
    end else if (w_capture) begin
      r_state   <= START;
      r_tx_out  <= UART_START_LVL;
      r_busy    <= 1'b1;
      r_par_en  <= bus.PAR_EN;
      r_par_bit <= (^bus.P_DATA) ^ bus.PAR_TYP;
`ifdef UART_TX_TWO_STOP_EN
      r_stop_second <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_tx_out <= UART_IDLE_LVL;
          r_busy   <= 1'b0;
        end
        START: begin
          r_state  <= DATA;
          r_tx_out <= w_bit;
        end
        DATA: begin
          if (!w_done) begin
            r_tx_out <= w_next_bit;
          end else if (r_par_en) begin
            r_state  <= PARITY;
            r_tx_out <= r_par_bit;
          end else begin
            r_state  <= STOP;
            r_tx_out <= UART_STOP_LVL;
          end
        end
        PARITY: begin
          r_state  <= STOP;
          r_tx_out <= UART_STOP_LVL;
        end
        STOP: begin
`ifdef UART_TX_TWO_STOP_EN
          if (!r_stop_second) begin
            r_stop_second <= 1'b1;
            r_tx_out      <= UART_STOP_LVL;
          end else begin
            r_stop_second <= 1'b0;
            r_state       <= IDLE;
            r_tx_out      <= UART_IDLE_LVL;
            r_busy        <= 1'b0;
          end
`else
          r_state  <= IDLE;
          r_tx_out <= UART_IDLE_LVL;
          r_busy   <= 1'b0;
`endif
        end
        default: begin
          r_state  <= IDLE;
          r_tx_out <= UART_IDLE_LVL;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.TX_OUT = r_tx_out;
  assign bus.Busy   = r_busy;

endmodule
